conv3x3_engine: RTL
===================

# conv3x3_engine

Consumes the 3x3 pixel windows produced by the line buffer and turns them into a stream of filtered output pixels. It drives the buffer's `win_ready` back-pressure input and applies a programmable signed 3x3 kernel. Accumulation is pipelined with shift-and-saturate normalisation. Output is a valid/ready pixel stream with row and frame markers for the downstream writer.

## Interface
- `WIDTH`, 32: input image width in pixels; output width is `WIDTH-2`.
- `HEIGHT`, 32: input image height in rows; output height is `HEIGHT-2`.
- `KERNEL_SIZE`, 3: fixed at 3. Any other value is unsupported.
- `SHIFT`, 4: arithmetic right shift applied to the sum before saturation.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rstb`  in  1  reset, asynchronous and active-low.
- `win_1` … `win_9`  in  8 each  unsigned window taps in row-major order: 1-3 top row, 7-9 bottom row.
- `win_cond`  in  1  window-content-valid qualifier from the buffer (its `in_row2_cond`).
- `buf_valid`  in  1  buffer presents a window.
- `win_ready`  out  1  engine can accept a window this cycle.
- `coef`  in  72  nine signed 8-bit coefficients; `coef[7:0]` pairs with `win_1`.
- `start`  in  1  single-cycle pulse; latches `coef` and clears the position counters.
- `out_pixel`  out  8  filtered pixel.
- `out_valid`  out  1  `out_pixel` is valid.
- `out_ready`  in  1  downstream accepts the pixel.
- `out_eol`  out  1  qualifies the last pixel of an output row.
- `out_eof`  out  1  qualifies the last pixel of the frame.
- `busy`  out  1  frame in progress.

## Operation
- A window is accepted when `buf_valid && win_cond && win_ready` in the same cycle. A window presented with `win_cond` low is ignored and not counted.
- `start` is honoured only when `busy` is 0. It latches `coef` into a kernel register and sets `busy`. While `busy` is 1, `start` is ignored.
- Windows presented while `busy` is 0 are not accepted. `win_ready` is 0 in that state.
- **S1 (multiply):** nine products, each unsigned 8-bit × signed 8-bit, giving signed 17-bit results.
- **S2 (adder tree):** signed 21-bit sum of the nine products. No overflow is possible at this width.
- **S3 (normalise):** arithmetic shift right by `SHIFT`, then clamp to the range 0..255.
- The output position counters advance on each output handshake:
  - `ocol` counts 0..`WIDTH-3`; `orow` counts 0..`HEIGHT-3`.
  - `out_eol` = (`ocol == WIDTH-3`).
  - `out_eof` = `out_eol && orow == HEIGHT-3`.
- On the `out_eof` handshake, `busy` clears and the counters return to 0.
- Reset values: `out_valid`, `out_eol`, `out_eof`, `busy` = 0; `out_pixel` = 0; kernel register = 0; all pipeline valid bits = 0.
- Reset asserted mid-frame discards every in-flight window. There is no partial flush.

## Timing
- Latency is 3 cycles from window acceptance to `out_valid`, assuming no stall.
- Throughput is one pixel per cycle while `out_ready` is held at 1.
- The pipeline has a single global enable: `en = !(s3_valid && !out_ready)`.
  - `win_ready = busy && en`; this is combinational from `out_ready`.
  - When `en` is 0, all stages hold, including the payload.
- While `out_valid` is 1 and `out_ready` is 0, `out_pixel`, `out_eol` and `out_eof` are stable.
- Bubbles: a stage with its valid bit at 0 still shifts when `en` is 1. Bubbles propagate and are never compressed.
- If `start` arrives in the same cycle as the final `out_eof` handshake, it is ignored, because `busy` is still 1 in that cycle.
- Counter wrap-around at `out_eol`: `ocol` goes to 0 and `orow` increments on the same edge.

## Structure
- Shared package `conv_pkg` holds:
  - constants `PIX_W = 8`, `COEF_W = 8`, `PROD_W = 17`, `SUM_W = 21`;
  - the clamp function.
- Sub-module `conv_adder_tree`: registered nine-input signed adder. It implements S2 and takes `en` and a valid input.
- The remainder is one module: multiply stage, normalise stage, kernel register, counters and handshake logic.

## Test plan
- **Identity kernel:** centre coefficient 16, all others 0, `SHIFT` 4, 32x32 ramp image. Expect `out_pixel` equal to the input centre tap for all 900 pixels. Expect `out_eol` on every 30th pixel and `out_eof` exactly once, on pixel 900.
- **Saturation:** all coefficients 127, all taps 255. Expect output 255. Then all coefficients −128 with the same taps: expect output 0.
- **Back-pressure:** toggle `out_ready` pseudo-randomly at 50%. Expect an output stream identical to the unstalled run. Expect `win_ready` to be 0 in every cycle where `out_valid && !out_ready`. Expect no pixel lost or duplicated.
- **Qualifier:** hold `buf_valid` at 1 with `win_cond` at 0 for 5 cycles. Expect no `out_valid`, and `ocol` to remain unchanged.
- **Reset mid-frame:** deassert `rstb` after 100 outputs. Expect every output at its reset value and `busy` = 0 immediately. After `start`, the new frame produces exactly 900 pixels.
- **Latency:** a single window with `out_ready` = 1 produces `out_valid` exactly 3 cycles after acceptance. A `start` while `busy` is 1 leaves the kernel register unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths and the output clamp for the 3x3 convolution engine.
package conv_pkg;

   localparam int PIX_W   = 8;
   localparam int COEF_W  = 8;
   localparam int PROD_W  = 17;
   localparam int SUM_W   = 21;
   localparam int TAPS    = 9;
   localparam int PIX_MAX = (1 << PIX_W) - 1;

   // Clamp a signed, already-shifted sum into the unsigned pixel range.
   function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [SUM_W-1:0] x);
      if (x < 0)
         return '0;
      else if (x > PIX_MAX)
         return PIX_W'(PIX_MAX);
      else
         return x[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// Window input bus (from the line buffer) and filtered pixel output stream.
interface conv_win_if;
   import conv_pkg::*;

   logic [PIX_W-1:0] win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9;
   logic             win_cond;
   logic             buf_valid;
   logic             win_ready;

   modport master (
      output win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9,
      output win_cond, buf_valid,
      input  win_ready
   );

   modport slave (
      input  win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8, win_9,
      input  win_cond, buf_valid,
      output win_ready
   );
endinterface

interface conv_pix_if;
   import conv_pkg::*;

   logic [PIX_W-1:0] out_pixel;
   logic             out_valid;
   logic             out_ready;
   logic             out_eol;
   logic             out_eof;

   modport master (output out_pixel, out_valid, out_eol, out_eof, input out_ready);
   modport slave  (input out_pixel, out_valid, out_eol, out_eof, output out_ready);
endinterface

// File: rtl/conv_adder_tree.sv
// Registered nine-input signed adder (S2); holds with the global pipeline enable.
module conv_adder_tree
   import conv_pkg::*;
(
   input  logic                     clk,
   input  logic                     rstb,
   input  logic                     en,
   input  logic                     in_valid,
   input  logic signed [PROD_W-1:0] prod [TAPS],
   output logic                     out_valid,
   output logic signed [SUM_W-1:0]  sum
);

   logic signed [SUM_W-1:0] total;

   // NOTE: default assignment first so no path through the block leaves total unassigned.
   always_comb begin
      total = '0;
      for (int i = 0; i < TAPS; i++)
         total = total + SUM_W'(prod[i]);
   end

   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         out_valid <= 1'b0;
         sum       <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         sum       <= total;
      end
   end

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 signed-kernel convolution: multiply, adder tree, shift-and-clamp, with
// a single stall enable and row/frame markers on the output stream.
module conv3x3_engine
   import conv_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int HEIGHT      = 32,
   parameter int KERNEL_SIZE = 3,
   parameter int SHIFT       = 4
) (
   input  logic                   clk,
   input  logic                   rstb,
   conv_win_if.slave              win,
   conv_pix_if.master             pix,
   input  logic [TAPS*COEF_W-1:0] coef,
   input  logic                   start,
   output logic                   busy
);

   // Only KERNEL_SIZE == 3 is supported; the tap count follows from it.
   localparam int NT = KERNEL_SIZE * KERNEL_SIZE;
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 3);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 3);

   logic [PIX_W-1:0]         taps   [TAPS];
   logic signed [COEF_W-1:0] kernel [TAPS];
   logic signed [PROD_W-1:0] s1_prod [TAPS];
   logic                     s1_valid, s2_valid;
   logic signed [SUM_W-1:0]  s2_sum, s2_shift;
   logic [CW-1:0]            ocol;
   logic [RW-1:0]            orow;
   logic                     en, accept, fire, last_col, last_row;

   assign taps[0] = win.win_1;
   assign taps[1] = win.win_2;
   assign taps[2] = win.win_3;
   assign taps[3] = win.win_4;
   assign taps[4] = win.win_5;
   assign taps[5] = win.win_6;
   assign taps[6] = win.win_7;
   assign taps[7] = win.win_8;
   assign taps[8] = win.win_9;

   // The only stall source is a held output pixel; every stage freezes on it.
   assign en            = !(pix.out_valid && !pix.out_ready);
   assign win.win_ready = busy && en;
   assign accept        = win.buf_valid && win.win_cond && win.win_ready;
   assign fire          = pix.out_valid && pix.out_ready;
   assign last_col      = (ocol == COL_LAST);
   assign last_row      = (orow == ROW_LAST);
   assign pix.out_eol   = pix.out_valid && last_col;
   assign pix.out_eof   = pix.out_eol && last_row;

   // NOTE: the kernel and stage payloads are flops rather than a RAM, so they
   // can take a reset and out_pixel comes up defined.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         busy <= 1'b0;
         ocol <= '0;
         orow <= '0;
         for (int i = 0; i < NT; i++)
            kernel[i] <= '0;
      end else if (!busy && start) begin
         busy <= 1'b1;
         ocol <= '0;
         orow <= '0;
         for (int i = 0; i < NT; i++)
            kernel[i] <= $signed(coef[i*COEF_W +: COEF_W]);
      end else if (busy && fire) begin
         if (last_col) begin
            ocol <= '0;
            if (last_row) begin
               orow <= '0;
               busy <= 1'b0;
            end else begin
               orow <= orow + 1'b1;
            end
         end else begin
            ocol <= ocol + 1'b1;
         end
      end
   end

   // S1: unsigned pixel times signed coefficient, zero-extended into a signed operand.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         s1_valid <= 1'b0;
         for (int i = 0; i < NT; i++)
            s1_prod[i] <= '0;
      end else if (en) begin
         s1_valid <= accept;
         for (int i = 0; i < NT; i++)
            s1_prod[i] <= PROD_W'($signed({1'b0, taps[i]})) * PROD_W'(kernel[i]);
      end
   end

   conv_adder_tree u_adder_tree (
      .clk       (clk),
      .rstb      (rstb),
      .en        (en),
      .in_valid  (s1_valid),
      .prod      (s1_prod),
      .out_valid (s2_valid),
      .sum       (s2_sum)
   );

   assign s2_shift = s2_sum >>> SHIFT;

   // S3: normalise and register the output pixel.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         pix.out_valid <= 1'b0;
         pix.out_pixel <= '0;
      end else if (en) begin
         pix.out_valid <= s2_valid;
         pix.out_pixel <= clamp_pix(s2_shift);
      end
   end

endmodule
